// File: rtl/vm2002_pkg.sv
// rtl/vm2002_pkg.sv - shared coin, button, item and status types for the vm2002 vending machine
package vm2002_pkg;

    typedef enum logic [1:0] {
        NICKEL      = 2'd0,
        DIME        = 2'd1,
        QUARTER     = 2'd2,
        ILLEGALCOIN = 2'd3
    } coins_t;

    typedef enum logic [2:0] {
        BTN_A = 3'd0,
        BTN_B = 3'd1,
        BTN_C = 3'd2,
        BTN_D = 3'd3,
        BTN_E = 3'd4,
        BTN_F = 3'd5,
        BTN_G = 3'd6,
        BTN_H = 3'd7
    } buttons_t;

    typedef enum logic [2:0] {
        WATER  = 3'd0,
        COLA   = 3'd1,
        PEPSI  = 3'd2,
        FANTA  = 3'd3,
        COFFEE = 3'd4,
        CHIPS  = 3'd5,
        BARS   = 3'd6,
        COOKIE = 3'd7
    } item_t;

    typedef enum logic [1:0] {
        AVAILABE     = 2'h0,
        OUT_OF_STOCK = 2'h1,
        ERROR        = 2'h2
    } status_t;

endpackage

// File: rtl/vm2002_vend_ctrl.sv
// rtl/vm2002_vend_ctrl.sv - vm2002 transaction controller (optional idle auto-refund via VM2002_AUTO_REFUND_EN)
module vm2002_vend_ctrl
    import vm2002_pkg::*;
#(
    parameter int MAX_CREDIT     = 60,
    parameter int INIT_COUNT     = 8,
    parameter int COUNT_W        = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin,
    input  logic       select_valid,
    input  logic [2:0] button,
    input  logic       cancel,
    input  logic       restock_valid,
    input  logic [2:0] restock_item,
    output logic       coin_reject,
    output logic       dispense_valid,
    output logic [2:0] dispense_item,
    output logic       change_valid,
    output logic [7:0] change_amount,
    output logic [7:0] credit,
    output logic [1:0] status,
    output logic       ready
);

    typedef enum logic [1:0] {
        S_COLLECT  = 2'd0,
        S_CHECK    = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    state_t             r_state;
    logic [7:0]         r_credit;
    item_t              r_sel;
    status_t            r_status;
    logic [COUNT_W-1:0] r_count [8];
    logic               r_coin_reject;
    logic               r_dispense_valid;
    logic [2:0]         r_dispense_item;
    logic               r_change_valid;
    logic [7:0]         r_change_amount;

`ifdef VM2002_AUTO_REFUND_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0]  r_idle;
`endif

    logic [7:0]         w_coin_value;
    logic               w_coin_legal;
    logic [8:0]         w_coin_sum;
    logic               w_coin_accept;
    logic [7:0]         w_credit_upd;
    logic [7:0]         w_sel_cost;
    logic [7:0]         w_remainder;

    // Fixed price list in nickels
    function automatic logic [7:0] item_cost(input item_t it);
        case (it)
            WATER:  item_cost = 8'd10;
            COLA:   item_cost = 8'd20;
            PEPSI:  item_cost = 8'd20;
            FANTA:  item_cost = 8'd20;
            COFFEE: item_cost = 8'd40;
            CHIPS:  item_cost = 8'd25;
            BARS:   item_cost = 8'd30;
            COOKIE: item_cost = 8'd35;
            default: item_cost = 8'd0;
        endcase
    endfunction

    // Decode the coin into its nickel value and legality
    always_comb begin
        w_coin_value = 8'd0;
        w_coin_legal = 1'b1;
        case (coins_t'(coin))
            NICKEL:      w_coin_value = 8'd1;
            DIME:        w_coin_value = 8'd2;
            QUARTER:     w_coin_value = 8'd5;
            ILLEGALCOIN: w_coin_legal = 1'b0;
            default:     w_coin_legal = 1'b0;
        endcase
    end

    // Coin acceptance and the credit a same-cycle select/cancel must see
    always_comb begin
        w_coin_sum    = {1'b0, r_credit} + {1'b0, w_coin_value};
        w_coin_accept = coin_valid && (r_state == S_COLLECT) && w_coin_legal
                        && (w_coin_sum <= 9'(MAX_CREDIT));
        w_credit_upd  = w_coin_accept ? w_coin_sum[7:0] : r_credit;
        w_sel_cost    = item_cost(r_sel);
        w_remainder   = r_credit - w_sel_cost;
    end

    // Transaction FSM with registered outputs, stock counters and restock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_COLLECT;
            r_credit         <= 8'd0;
            r_sel            <= WATER;
            r_status         <= AVAILABE;
            r_coin_reject    <= 1'b0;
            r_dispense_valid <= 1'b0;
            r_dispense_item  <= 3'd0;
            r_change_valid   <= 1'b0;
            r_change_amount  <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                r_count[i] <= COUNT_W'(INIT_COUNT);
            end
`ifdef VM2002_AUTO_REFUND_EN
            r_idle           <= '0;
`endif
        end else begin
            r_coin_reject    <= coin_valid && !w_coin_accept;
            r_dispense_valid <= 1'b0;
            r_change_valid   <= 1'b0;

            case (r_state)
                S_COLLECT: begin
                    if (w_coin_accept) begin
                        r_credit <= w_credit_upd;
                        r_status <= AVAILABE;
                    end
                    if (cancel) begin
                        if (w_credit_upd != 8'd0) begin
                            r_state         <= S_CHANGE;
                            r_change_valid  <= 1'b1;
                            r_change_amount <= w_credit_upd;
                        end
                    end else if (select_valid) begin
                        r_sel   <= item_t'(button);
                        r_state <= S_CHECK;
                    end
`ifdef VM2002_AUTO_REFUND_EN
                    if (cancel || select_valid || w_coin_accept || (r_credit == 8'd0)) begin
                        r_idle <= '0;
                    end else if (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                        r_idle          <= '0;
                        r_state         <= S_CHANGE;
                        r_change_valid  <= 1'b1;
                        r_change_amount <= r_credit;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
`endif
                end
                S_CHECK: begin
                    if (r_count[r_sel] == '0) begin
                        r_status <= OUT_OF_STOCK;
                        r_state  <= S_COLLECT;
                    end else if (r_credit < w_sel_cost) begin
                        r_status <= ERROR;
                        r_state  <= S_COLLECT;
                    end else begin
                        r_status         <= AVAILABE;
                        r_state          <= S_DISPENSE;
                        r_dispense_valid <= 1'b1;
                        r_dispense_item  <= r_sel;
                    end
                end
                S_DISPENSE: begin
                    r_credit <= w_remainder;
                    if (r_count[r_sel] != '0) begin
                        r_count[r_sel] <= r_count[r_sel] - COUNT_W'(1);
                    end
                    if (w_remainder != 8'd0) begin
                        r_state         <= S_CHANGE;
                        r_change_valid  <= 1'b1;
                        r_change_amount <= w_remainder;
                    end else begin
                        r_state <= S_COLLECT;
                    end
                end
                S_CHANGE: begin
                    r_credit <= 8'd0;
                    r_state  <= S_COLLECT;
                end
                default: r_state <= S_COLLECT;
            endcase

            // Placed after the dispense decrement so a coincident restock wins
            if (restock_valid) begin
                r_count[restock_item] <= COUNT_W'(INIT_COUNT);
            end
        end
    end

    assign coin_reject    = r_coin_reject;
    assign dispense_valid = r_dispense_valid;
    assign dispense_item  = r_dispense_item;
    assign change_valid   = r_change_valid;
    assign change_amount  = r_change_amount;
    assign credit         = r_credit;
    assign status         = r_status;
    assign ready          = (r_state == S_COLLECT);

endmodule

// File: tb/tb_vm2002_vend_ctrl.sv
// tb/tb_vm2002_vend_ctrl.sv - scoreboard bench for vm2002_vend_ctrl
module tb_vm2002_vend_ctrl;
    import vm2002_pkg::*;

    logic       clk;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin;
    logic       select_valid;
    logic [2:0] button;
    logic       cancel;
    logic       restock_valid;
    logic [2:0] restock_item;
    logic       coin_reject;
    logic       dispense_valid;
    logic [2:0] dispense_item;
    logic       change_valid;
    logic [7:0] change_amount;
    logic [7:0] credit;
    logic [1:0] status;
    logic       ready;

    typedef struct {
        logic       is_change;
        logic [7:0] val;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  checks = 0;
    int  errors = 0;

    vm2002_vend_ctrl #(
        .MAX_CREDIT(60),
        .INIT_COUNT(8),
        .COUNT_W(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .coin_valid(coin_valid),
        .coin(coin),
        .select_valid(select_valid),
        .button(button),
        .cancel(cancel),
        .restock_valid(restock_valid),
        .restock_item(restock_item),
        .coin_reject(coin_reject),
        .dispense_valid(dispense_valid),
        .dispense_item(dispense_item),
        .change_valid(change_valid),
        .change_amount(change_amount),
        .credit(credit),
        .status(status),
        .ready(ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every dispense/change pulse must match the next expected event
    always @(negedge clk) begin
        if (dispense_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_dispense_unexpected got item %0d required no event", dispense_item);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_change !== 1'b0 || mon_e.val[2:0] !== dispense_item) begin
                    errors++;
                    $display("FAIL sb_dispense got item %0d required change=%0d val=%0d",
                             dispense_item, mon_e.is_change, mon_e.val);
                end
            end
        end
        if (change_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_change_unexpected got amount %0d required no event", change_amount);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_change !== 1'b1 || mon_e.val !== change_amount) begin
                    errors++;
                    $display("FAIL sb_change got amount %0d required change=%0d val=%0d",
                             change_amount, mon_e.is_change, mon_e.val);
                end
            end
        end
    end

    task automatic push_disp(input logic [2:0] it);
        ev_t e;
        e.is_change = 1'b0;
        e.val       = {5'd0, it};
        exp_q.push_back(e);
    endtask

    task automatic push_change(input logic [7:0] amt);
        ev_t e;
        e.is_change = 1'b1;
        e.val       = amt;
        exp_q.push_back(e);
    endtask

    task automatic coin_in(input logic [1:0] c);
        coin       = c;
        coin_valid = 1'b1;
        @(negedge clk);
        coin_valid = 1'b0;
    endtask

    task automatic press(input logic [2:0] b);
        button       = b;
        select_valid = 1'b1;
        @(negedge clk);
        select_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_timeout got ready %b required 1", name, ready);
        end
    endtask

    task automatic check_q_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending_events got %0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({coin_reject, dispense_valid, change_valid, credit, status, change_amount, dispense_item} !== '0
            || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values got rej=%b dv=%b cv=%b cr=%0d st=%0d ca=%0d di=%0d rdy=%b required all 0 rdy=1",
                     coin_reject, dispense_valid, change_valid, credit, status, change_amount, dispense_item, ready);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vend_water();
        coin_in(QUARTER);
        coin_in(QUARTER);
        checks++;
        if (credit !== 8'd10) begin errors++; $display("FAIL water_credit got %0d required 10", credit); end
        push_disp(WATER);
        press(BTN_A);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL water_check_busy got ready %b required 0", ready); end
        @(negedge clk);
        checks++;
        if (dispense_valid !== 1'b1 || dispense_item !== 3'(WATER)) begin
            errors++;
            $display("FAIL water_dispense got dv=%b item=%0d required dv=1 item=%0d", dispense_valid, dispense_item, WATER);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || credit !== 8'd0 || change_valid !== 1'b0) begin
            errors++;
            $display("FAIL water_after got rdy=%b cr=%0d cv=%b required rdy=1 cr=0 cv=0", ready, credit, change_valid);
        end
        check_q_empty("water");
    endtask

    task automatic test_insufficient();
        coin_in(DIME);
        coin_in(QUARTER);
        checks++;
        if (credit !== 8'd7) begin errors++; $display("FAIL insuf_credit got %0d required 7", credit); end
        press(BTN_B);
        coin_in(NICKEL);
        checks++;
        if (status !== 2'(ERROR) || ready !== 1'b1 || credit !== 8'd7) begin
            errors++;
            $display("FAIL insuf_status got st=%0d rdy=%b cr=%0d required st=%0d rdy=1 cr=7", status, ready, credit, ERROR);
        end
        checks++;
        if (coin_reject !== 1'b1) begin errors++; $display("FAIL busy_coin_reject got %b required 1", coin_reject); end
        push_change(8'd7);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checks++;
        if (change_valid !== 1'b1 || change_amount !== 8'd7) begin
            errors++;
            $display("FAIL cancel_change got cv=%b amt=%0d required cv=1 amt=7", change_valid, change_amount);
        end
        wait_ready("cancel");
        checks++;
        if (credit !== 8'd0) begin errors++; $display("FAIL cancel_credit got %0d required 0", credit); end
        check_q_empty("insuf");
    endtask

    task automatic test_stock();
        for (int k = 0; k < 8; k++) begin
            repeat (4) coin_in(QUARTER);
            push_disp(COLA);
            press(BTN_B);
            @(negedge clk);
            wait_ready("stock_drain");
        end
        check_q_empty("stock_drain");
        repeat (4) coin_in(QUARTER);
        press(BTN_B);
        @(negedge clk);
        checks++;
        if (status !== 2'(OUT_OF_STOCK) || credit !== 8'd20 || ready !== 1'b1) begin
            errors++;
            $display("FAIL out_of_stock got st=%0d cr=%0d rdy=%b required st=%0d cr=20 rdy=1", status, credit, ready, OUT_OF_STOCK);
        end
        restock_item  = COLA;
        restock_valid = 1'b1;
        @(negedge clk);
        restock_valid = 1'b0;
        push_disp(COLA);
        press(BTN_B);
        @(negedge clk);
        checks++;
        if (dispense_valid !== 1'b1) begin errors++; $display("FAIL restock_dispense got %b required 1", dispense_valid); end
        wait_ready("restock");
        checks++;
        if (credit !== 8'd0 || status !== 2'(AVAILABE)) begin
            errors++;
            $display("FAIL restock_after got cr=%0d st=%0d required cr=0 st=0", credit, status);
        end
        check_q_empty("stock");
    endtask

    task automatic test_max_credit();
        repeat (12) coin_in(QUARTER);
        checks++;
        if (credit !== 8'd60) begin errors++; $display("FAIL max_credit got %0d required 60", credit); end
        coin_in(NICKEL);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 8'd60) begin
            errors++;
            $display("FAIL overflow_reject got rej=%b cr=%0d required rej=1 cr=60", coin_reject, credit);
        end
        coin_in(ILLEGALCOIN);
        checks++;
        if (coin_reject !== 1'b1) begin errors++; $display("FAIL illegal_reject got %b required 1", coin_reject); end
        push_disp(COFFEE);
        push_change(8'd20);
        press(BTN_E);
        @(negedge clk);
        checks++;
        if (dispense_valid !== 1'b1 || dispense_item !== 3'(COFFEE)) begin
            errors++;
            $display("FAIL coffee_dispense got dv=%b item=%0d required dv=1 item=%0d", dispense_valid, dispense_item, COFFEE);
        end
        @(negedge clk);
        checks++;
        if (change_valid !== 1'b1 || change_amount !== 8'd20 || credit !== 8'd20) begin
            errors++;
            $display("FAIL coffee_change got cv=%b amt=%0d cr=%0d required cv=1 amt=20 cr=20", change_valid, change_amount, credit);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || credit !== 8'd0) begin
            errors++;
            $display("FAIL coffee_after got rdy=%b cr=%0d required rdy=1 cr=0", ready, credit);
        end
        check_q_empty("max");
    endtask

    task automatic test_same_cycle();
        logic [1:0] coins [2];
        logic [7:0] amts [2];
        coins[0] = QUARTER;     amts[0] = 8'd10;
        coins[1] = ILLEGALCOIN; amts[1] = 8'd5;
        for (int k = 0; k < 2; k++) begin
            coin_in(QUARTER);
            push_change(amts[k]);
            coin         = coins[k];
            coin_valid   = 1'b1;
            button       = BTN_A;
            select_valid = 1'b1;
            cancel       = 1'b1;
            @(negedge clk);
            coin_valid   = 1'b0;
            select_valid = 1'b0;
            cancel       = 1'b0;
            checks++;
            if (change_valid !== 1'b1 || change_amount !== amts[k] || ready !== 1'b0) begin
                errors++;
                $display("FAIL same_cycle_%0d got cv=%b amt=%0d rdy=%b required cv=1 amt=%0d rdy=0",
                         k, change_valid, change_amount, ready, amts[k]);
            end
            wait_ready("same_cycle");
            checks++;
            if (credit !== 8'd0) begin errors++; $display("FAIL same_cycle_credit got %0d required 0", credit); end
        end
        check_q_empty("same_cycle");
    endtask

    task automatic test_reset_mid();
        coin_in(QUARTER);
        coin_in(QUARTER);
        push_disp(WATER);
        press(BTN_A);
        @(negedge clk);
        checks++;
        if (dispense_valid !== 1'b1) begin errors++; $display("FAIL midreset_pre got dv=%b required 1", dispense_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (dispense_valid !== 1'b0 || change_valid !== 1'b0 || credit !== 8'd0 || ready !== 1'b1 || status !== 2'd0) begin
            errors++;
            $display("FAIL midreset_values got dv=%b cv=%b cr=%0d rdy=%b st=%0d required 0 0 0 1 0",
                     dispense_valid, change_valid, credit, ready, status);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (credit !== 8'd0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_after got cr=%0d rdy=%b required cr=0 rdy=1", credit, ready);
        end
        check_q_empty("midreset");
    endtask

    task automatic test_auto_refund();
        coin_in(DIME);
`ifdef VM2002_AUTO_REFUND_EN
        begin
            int  n;
            bit  seen;
            seen = 1'b0;
            n    = 0;
            push_change(8'd2);
            while (!seen && n < 40) begin
                @(negedge clk);
                n++;
                if (change_valid === 1'b1) seen = 1'b1;
            end
            checks++;
            if (!seen || n < 10 || n > 24) begin
                errors++;
                $display("FAIL auto_refund got seen=%b after %0d cycles required seen=1 near 16", seen, n);
            end
            wait_ready("auto_refund");
        end
`else
        repeat (40) @(negedge clk);
        checks++;
        if (credit !== 8'd2 || ready !== 1'b1) begin
            errors++;
            $display("FAIL no_auto_refund got cr=%0d rdy=%b required cr=2 rdy=1", credit, ready);
        end
        push_change(8'd2);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        wait_ready("no_auto_refund");
`endif
        checks++;
        if (credit !== 8'd0) begin errors++; $display("FAIL refund_credit got %0d required 0", credit); end
        check_q_empty("refund");
    endtask

    initial begin
        reset         = 1'b1;
        coin_valid    = 1'b0;
        coin          = 2'd0;
        select_valid  = 1'b0;
        button        = 3'd0;
        cancel        = 1'b0;
        restock_valid = 1'b0;
        restock_item  = 3'd0;
        test_reset();
        test_vend_water();
        test_insufficient();
        test_stock();
        test_max_credit();
        test_same_cycle();
        test_reset_mid();
        test_auto_refund();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
